hive_stk_ctl: RTL and testbench
===============================

# hive_stk_ctl

Stack clear scheduler and error tracker for the hive barrel processor's per-thread stacks. It queues per-thread clear requests and issues the `cls_o` vector to the stacks block only in the pipeline slot owned by the requesting thread. It also attributes the stacks' pop/push error strobes back to the offending thread via an id delay line, and keeps sticky per-thread error flags with an interrupt output. It sits between the thread/register control logic and the stacks block.

## Interface
- `THREADS`, 8, number of barrel threads (power of 2)
- `STACKS`, 8, stacks per thread
- `ID_W`, 3, thread id width, log2(THREADS)
- `ERR_LAT`, 8, cycles from id_i slot to the arrival of the matching error strobe (≥2)

- `clk_i`  in  1  clock
- `rst_n_i`  in  1  asynchronous reset, active low
- `id_i`  in  ID_W  thread id of the current slot; increments mod THREADS every cycle
- `clr_req_i`  in  THREADS  per-thread clear request, 1-cycle pulse
- `clr_mask_i`  in  STACKS  stacks to clear; sampled with any `clr_req_i` bit
- `clr_busy_o`  out  THREADS  per-thread clear pending
- `cls_o`  out  STACKS  per-stack clear to the stacks block, registered
- `pop_er_i`  in  1  pop-when-empty strobe from the stacks block
- `psh_er_i`  in  1  push-when-full strobe from the stacks block
- `err_clr_i`  in  THREADS  per-thread error flag clear, pulse
- `irq_en_i`  in  THREADS  per-thread interrupt enable
- `pop_err_o`  out  THREADS  sticky pop error flags
- `psh_err_o`  out  THREADS  sticky push error flags
- `irq_o`  out  1  registered OR of `(pop_err_o | psh_err_o) & irq_en_i`

## Operation
- Per-thread state: `pend[t]` (1 bit) and `mask[t]` (STACKS bits).
- Request: when `clr_req_i[t]` is set, `pend[t] <= 1`. If thread t is already pending and not issuing this cycle, `mask[t] <= mask[t] | clr_mask_i`; otherwise `mask[t] <= clr_mask_i`.
- Issue: in any cycle with `pend[id_i]` set, `cls_o <= mask[id_i]`; otherwise `cls_o <= 0`. The same cycle clears `pend[id_i]`, `pop_err[id_i]` and `psh_err[id_i]`.
- Issue and new request for the same thread in the same cycle: the issue uses the old mask. The new request stays pending with `clr_mask_i` only and issues on the next rotation.
- A request arriving while `id_i == t` and not pending does not issue this cycle. The earliest issue is the next rotation, up to THREADS cycles later.
- A request with an all-zero mask still pends and issues. `cls_o` stays 0, but the thread's error flags are cleared.
- Error attribution: `id_i` feeds an ERR_LAT-deep register delay line (`id_d`).
  - `pop_er_i` sets `pop_err[id_d]`; `psh_er_i` sets `psh_err[id_d]`.
- Flag priority, for the same thread in the same cycle: error set beats `err_clr_i`, and error set beats a clear issue.
- `clr_busy_o = pend`, driven straight from the register.

## Timing
- Reset values: `pend`, `mask`, `cls_o`, `pop_err_o`, `psh_err_o` and `irq_o` are 0, and the `id_d` line is 0.
- Reset deasserting mid-queue: all pending clears are dropped and the requester must re-issue.
- `cls_o` is valid 1 cycle after the slot with `id_i == t`. The integrator feeds an `id_i` that leads the stacks' clear-consumption stage by 1.
- Request to `cls_o` latency: 2 to THREADS+1 cycles.
- Error strobe to flag: 1 cycle. Flag to `irq_o`: 1 cycle.
- No handshake beyond `clr_busy_o`. Software polls or waits for it to fall.

## Structure
- Shared package (`hive_params`) holds THREADS, STACKS, ID_W and ERR_LAT, with the ERR_LAT default matching the stacks block's error latency of 8.
- The `id_d` delay line reuses the existing `pipe` module (DEPTH=ERR_LAT, WIDTH=ID_W, RESET_VAL=0).
- No other sub-module; per-thread state is a generate loop.

## Test plan
- Reset with `id_i` cycling 0..7, then `clr_req_i=8'h04` and `clr_mask_i=8'h81` at `id_i=5` → `cls_o=8'h81` for exactly one cycle, the cycle after `id_i=2`. `clr_busy_o[2]` reads 1 until that slot and is 0 afterwards.
- Thread 3 mask `8'h01`, then `8'h10` two cycles later, both before its slot → single issue with `cls_o=8'h11`.
- Request for thread 6 (mask `8'h02`) in the cycle its slot issues a pending mask `8'h01` → `cls_o=8'h01` now, then `8'h02` exactly THREADS cycles later.
- `pop_er_i` pulsed when `id_d=4` (ERR_LAT after the thread-4 slot) → `pop_err_o=8'h10`. With `irq_en_i=8'h10`, `irq_o=1` one cycle later. `err_clr_i=8'h10` → both drop.
- `psh_er_i` for thread 1 in the same cycle as `err_clr_i[1]` → `psh_err_o[1]` stays 1.
- Assert `rst_n_i=0` with threads 0 and 7 pending → `clr_busy_o=0`, and no `cls_o` pulse after release.

Source files
------------

// File: rtl/hive_params.sv
// Shared hive sizing constants.
//   THREADS : number of barrel threads (power of 2)
//   STACKS  : stacks per thread
//   ID_W    : thread id width, log2(THREADS)
//   ERR_LAT : cycles from an id slot to its matching stacks error strobe
package hive_params;

  localparam int unsigned THREADS = 8;
  localparam int unsigned STACKS  = 8;
  localparam int unsigned ID_W    = 3;
  // Matches the stacks block's error strobe latency.
  localparam int unsigned ERR_LAT = 8;

endpackage

// File: rtl/pipe.sv
// Generic register delay line with reset value.
//   clk_i   : clock
//   rst_n_i : asynchronous reset, active low
//   d_i     : data in
//   q_o     : data in delayed by DEPTH cycles
module pipe #(
  parameter int unsigned        DEPTH     = 2,
  parameter int unsigned        WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/hive_stk_ctl.sv
// Stack clear scheduler and error tracker for the per-thread stacks.
// Queues per-thread clear requests and issues them on cls_o only in the
// slot owned by the requesting thread; attributes stack pop/push error
// strobes to the thread whose slot produced them and keeps sticky flags.
//   clk_i, rst_n_i     : clock, asynchronous active-low reset
//   id_i               : current slot thread id (rotates every cycle)
//   clr_req_i          : per-thread clear request pulses
//   clr_mask_i         : stacks to clear, sampled with any request
//   clr_busy_o         : per-thread clear pending
//   cls_o              : registered per-stack clear to the stacks block
//   pop_er_i, psh_er_i : error strobes from the stacks block
//   err_clr_i          : per-thread error flag clear
//   irq_en_i           : per-thread interrupt enable
//   pop_err_o, psh_err_o : sticky per-thread error flags
//   irq_o              : registered OR of enabled flags
module hive_stk_ctl #(
  parameter int unsigned THREADS = hive_params::THREADS,
  parameter int unsigned STACKS  = hive_params::STACKS,
  parameter int unsigned ID_W    = hive_params::ID_W,
  parameter int unsigned ERR_LAT = hive_params::ERR_LAT
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [ID_W-1:0]    id_i,
  input  logic [THREADS-1:0] clr_req_i,
  input  logic [STACKS-1:0]  clr_mask_i,
  output logic [THREADS-1:0] clr_busy_o,
  output logic [STACKS-1:0]  cls_o,
  input  logic               pop_er_i,
  input  logic               psh_er_i,
  input  logic [THREADS-1:0] err_clr_i,
  input  logic [THREADS-1:0] irq_en_i,
  output logic [THREADS-1:0] pop_err_o,
  output logic [THREADS-1:0] psh_err_o,
  output logic               irq_o
);

  logic [ID_W-1:0]    id_d;
  logic [THREADS-1:0] pend_vec;
  logic [STACKS-1:0]  mask_all [THREADS];
  logic [STACKS-1:0]  cls_d, cls_q;
  logic               irq_d, irq_q;

  // Slot id delayed to line up with the stacks' error strobes.
  pipe #(
    .DEPTH     (ERR_LAT),
    .WIDTH     (ID_W),
    .RESET_VAL ('0)
  ) u_id_pipe (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (id_i),
    .q_o     (id_d)
  );

  for (genvar t = 0; t < THREADS; t++) begin : g_thr
    logic              pend_d, pend_q;
    logic [STACKS-1:0] mask_d, mask_q;
    logic              pop_d, pop_q;
    logic              psh_d, psh_q;
    logic              issue;
    logic              err_hit;

    assign issue   = pend_q && (id_i == ID_W'(t));
    assign err_hit = (id_d == ID_W'(t));

    always_comb begin
      pend_d = pend_q;
      mask_d = mask_q;
      if (clr_req_i[t]) begin
        pend_d = 1'b1;
        // Merge only into a request that is still waiting; an issuing
        // request has consumed the old mask.
        mask_d = (pend_q && !issue) ? (mask_q | clr_mask_i) : clr_mask_i;
      end else if (issue) begin
        pend_d = 1'b0;
      end
    end

    // Error set wins over both software clear and a clear issue.
    always_comb begin
      pop_d = pop_q;
      psh_d = psh_q;
      if (err_clr_i[t] || issue) begin
        pop_d = 1'b0;
        psh_d = 1'b0;
      end
      if (pop_er_i && err_hit) pop_d = 1'b1;
      if (psh_er_i && err_hit) psh_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        pend_q <= 1'b0;
        mask_q <= '0;
        pop_q  <= 1'b0;
        psh_q  <= 1'b0;
      end else begin
        pend_q <= pend_d;
        mask_q <= mask_d;
        pop_q  <= pop_d;
        psh_q  <= psh_d;
      end
    end

    assign pend_vec[t]  = pend_q;
    assign mask_all[t]  = mask_q;
    assign pop_err_o[t] = pop_q;
    assign psh_err_o[t] = psh_q;
  end

  always_comb begin
    cls_d = '0;
    if (pend_vec[id_i]) cls_d = mask_all[id_i];
  end

  assign irq_d = |((pop_err_o | psh_err_o) & irq_en_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cls_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cls_q <= cls_d;
      irq_q <= irq_d;
    end
  end

  assign clr_busy_o = pend_vec;
  assign cls_o      = cls_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_hive_stk_ctl.sv
// Self-checking bench for hive_stk_ctl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_hive_stk_ctl;

  localparam int T  = 8;
  localparam int S  = 8;
  localparam int IW = 3;
  localparam int EL = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] id_i;
  logic [T-1:0]  clr_req, err_clr, irq_en;
  logic [S-1:0]  clr_mask;
  logic          pop_er, psh_er;
  logic [T-1:0]  clr_busy, pop_err, psh_err;
  logic [S-1:0]  cls;
  logic          irq;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state (what the outputs must read now).
  logic [T-1:0] m_pend;
  logic [S-1:0] m_mask [T];
  logic [S-1:0] m_cls;
  logic [T-1:0] m_pop, m_psh;
  logic         m_irq;
  int           hist [EL];  // hist[k]: slot id k+1 cycles ago

  always #5 clk = ~clk;

  hive_stk_ctl dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .id_i       (id_i),
    .clr_req_i  (clr_req),
    .clr_mask_i (clr_mask),
    .clr_busy_o (clr_busy),
    .cls_o      (cls),
    .pop_er_i   (pop_er),
    .psh_er_i   (psh_er),
    .err_clr_i  (err_clr),
    .irq_en_i   (irq_en),
    .pop_err_o  (pop_err),
    .psh_err_o  (psh_err),
    .irq_o      (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    for (int t = 0; t < T; t++) m_mask[t] = '0;
    m_cls = '0;
    m_pop = '0;
    m_psh = '0;
    m_irq = 1'b0;
    for (int k = 0; k < EL; k++) hist[k] = 0;
  endtask

  // Advance one clock: compute the model's next state from the applied
  // inputs, pass the edge, commit, then clear pulse inputs and rotate id.
  task automatic step();
    logic [T-1:0] n_pend, n_pop, n_psh;
    logic [S-1:0] n_mask [T];
    logic [S-1:0] n_cls;
    logic         n_irq;
    int           cur, ed;
    cur = int'(id_i);
    ed  = hist[EL-1];
    n_cls = m_pend[cur] ? m_mask[cur] : '0;
    for (int t = 0; t < T; t++) begin
      bool_iss: begin
        bit iss;
        iss = m_pend[t] && (t == cur);
        n_pend[t] = clr_req[t] ? 1'b1 : (iss ? 1'b0 : m_pend[t]);
        if (clr_req[t])
          n_mask[t] = (m_pend[t] && t != cur) ? (m_mask[t] | clr_mask) : clr_mask;
        else
          n_mask[t] = m_mask[t];
        n_pop[t] = (pop_er && ed == t) ? 1'b1 : ((err_clr[t] || iss) ? 1'b0 : m_pop[t]);
        n_psh[t] = (psh_er && ed == t) ? 1'b1 : ((err_clr[t] || iss) ? 1'b0 : m_psh[t]);
      end
    end
    n_irq = |((m_pop | m_psh) & irq_en);
    @(posedge clk);
    if (rst_n) begin
      m_pend = n_pend;
      for (int t = 0; t < T; t++) m_mask[t] = n_mask[t];
      m_cls = n_cls;
      m_pop = n_pop;
      m_psh = n_psh;
      m_irq = n_irq;
      for (int k = EL - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = cur;
    end else begin
      model_reset();
    end
    #1;
    clr_req  = '0;
    clr_mask = '0;
    err_clr  = '0;
    pop_er   = 1'b0;
    psh_er   = 1'b0;
    id_i     = id_i + 1'b1;
  endtask

  task automatic run_to(input int target);
    for (int n = 0; n < T && int'(id_i) != target; n++) step();
  endtask

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("m_cls", 32'(cls), 32'(m_cls));
        chk("m_busy", 32'(clr_busy), 32'(m_pend));
        chk("m_pop", 32'(pop_err), 32'(m_pop));
        chk("m_psh", 32'(psh_err), 32'(m_psh));
        chk("m_irq", 32'(irq), 32'(m_irq));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; id_i = '0; clr_req = '0; clr_mask = '0; err_clr = '0;
    irq_en = '0; pop_er = 1'b0; psh_er = 1'b0;
    model_reset();
    #1;
    chk_en = 1'b1;
    for (int i = 0; i < T; i++) step();
    chk("rst_cls", 32'(cls), 32'h0);
    chk("rst_busy", 32'(clr_busy), 32'h0);
    chk("rst_flags", 32'({pop_err, psh_err, 7'd0, irq}), 32'h0);
    rst_n = 1'b1;
    step();

    // Single request, thread 2, issued in the slot after id 2.
    run_to(5);
    clr_req = 8'h04; clr_mask = 8'h81;
    step();
    chk("t1_busy_wait", 32'(clr_busy[2]), 32'h1);
    run_to(2);
    chk("t1_busy_pre", 32'(clr_busy[2]), 32'h1);
    chk("t1_cls_pre", 32'(cls), 32'h0);
    step();
    chk("t1_cls", 32'(cls), 32'h81);
    chk("t1_busy_post", 32'(clr_busy[2]), 32'h0);
    step();
    chk("t1_cls_once", 32'(cls), 32'h0);

    // Two merged requests for thread 3.
    run_to(6);
    clr_req = 8'h08; clr_mask = 8'h01;
    step(); step();
    clr_req = 8'h08; clr_mask = 8'h10;
    step();
    run_to(3);
    step();
    chk("t2_merge", 32'(cls), 32'h11);

    // Request for thread 6 during its own issue slot.
    run_to(0);
    clr_req = 8'h40; clr_mask = 8'h01;
    step();
    run_to(6);
    clr_req = 8'h40; clr_mask = 8'h02;
    step();
    chk("t3_old", 32'(cls), 32'h01);
    chk("t3_busy", 32'(clr_busy[6]), 32'h1);
    for (int i = 0; i < T - 1; i++) step();
    step();
    chk("t3_new", 32'(cls), 32'h02);

    // Pop error attributed to thread 4, irq, then software clear.
    irq_en = 8'h10;
    run_to(4);
    pop_er = 1'b1;
    step();
    chk("t4_pop", 32'(pop_err), 32'h10);
    step();
    chk("t4_irq", 32'(irq), 32'h1);
    err_clr = 8'h10;
    step();
    chk("t4_pop_clr", 32'(pop_err), 32'h0);
    step();
    chk("t4_irq_clr", 32'(irq), 32'h0);

    // Error set beats software clear.
    run_to(1);
    psh_er = 1'b1; err_clr = 8'h02;
    step();
    chk("t5_psh_wins", 32'(psh_err[1]), 32'h1);
    err_clr = 8'h02;
    step();
    chk("t5_psh_clr", 32'(psh_err[1]), 32'h0);

    // Reset with threads 0 and 7 pending drops both.
    run_to(2);
    clr_req = 8'h81; clr_mask = 8'hff;
    step();
    chk("t6_busy", 32'(clr_busy), 32'h81);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_busy_rst", 32'(clr_busy), 32'h0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_no_cls", 32'(cls), 32'h0);
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        clr_req  = T'($urandom);
        clr_mask = S'($urandom);
      end
      if ($urandom_range(0, 7) == 0) err_clr = T'($urandom);
      pop_er = ($urandom_range(0, 7) == 0);
      psh_er = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) irq_en = T'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
      end
      step();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
